// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE feeder: channel/top state encodings
// and the IFMap row-flag bit positions seen by the PE scratch-pad controller.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ISSUE,
    CH_DRAIN,
    CH_DONE
  } chan_state_t;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_RUN,
    TOP_FINISH
  } top_state_t;

  localparam int IFMAP_WIDTH_DEF = 18;
  localparam int SOR_BIT         = IFMAP_WIDTH_DEF - 1;
  localparam int EOR_BIT         = IFMAP_WIDTH_DEF - 2;

endpackage

// File: rtl/pe_feeder_feed_channel.sv
// One memory-to-FIFO feed channel: address/count generator, issue logic and a
// one-cycle write-strobe pipe, with optional start/end-of-row tagging.
module feed_channel
  import pe_feeder_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RDATA_W = 8,
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 8,
  parameter bit ROW_TAG = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  base,
  input  logic [LEN_W-1:0]   row_len,
  input  logic [LEN_W-1:0]   num_rows,
  input  logic               ready,
  output logic               mem_ren,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [RDATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0]  wr_data,
  output logic               wr_en,
  output logic               fin
);

  chan_state_t        state, state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   col_q, row_q, len_q, rows_q;
  logic               wr_en_q;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  wr_word;
  logic               issue, last_col, last_row, zero_len;

  assign issue    = (state == CH_ISSUE) && ready;
  assign last_col = (col_q == len_q - LEN_W'(1));
  assign last_row = (row_q == rows_q - LEN_W'(1));
  assign zero_len = (row_len == '0) || (num_rows == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CH_IDLE;
    else     state <= state_nxt;
  end

  // DRAIN always lasts one cycle: its first cycle carries the final write.
  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE:  if (start) state_nxt = zero_len ? CH_DONE : CH_ISSUE;
      CH_ISSUE: if (issue && last_col && last_row) state_nxt = CH_DRAIN;
      CH_DRAIN: if (wr_en_q) state_nxt = CH_DONE;
      CH_DONE:  if (clear) state_nxt = CH_IDLE;
      default:  state_nxt = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      len_q   <= '0;
      rows_q  <= '0;
      wr_en_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      wr_en_q <= issue;
      if (state == CH_IDLE && start) begin
        addr_q <= base;
        col_q  <= '0;
        row_q  <= '0;
        len_q  <= row_len;
        rows_q <= num_rows;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + LEN_W'(1);
        end else begin
          col_q <= col_q + LEN_W'(1);
        end
      end
      if (wr_en_q) hold_q <= wr_word;
    end
  end

  generate
    if (ROW_TAG) begin : g_tag
      logic sor_q, eor_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sor_q <= 1'b0;
          eor_q <= 1'b0;
        end else if (issue) begin
          sor_q <= (col_q == '0);
          eor_q <= last_col;
        end
      end
      assign wr_word = {sor_q, eor_q, mem_rdata};
    end else begin : g_plain
      assign wr_word = mem_rdata;
    end
  endgenerate

  // Output word only moves with the strobe; otherwise the last written word is held.
  assign wr_data  = wr_en_q ? wr_word : hold_q;
  assign wr_en    = wr_en_q;
  assign mem_ren  = issue;
  assign mem_addr = addr_q;
  assign fin      = (state == CH_DONE) || (state == CH_DRAIN && wr_en_q);

endmodule

// File: rtl/pe_feeder.sv
// Job-level feeder: runs the filter and IFMap channels concurrently from one
// start pulse and reports completion with a single-cycle done.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int IFMAP_WIDTH          = 18,
  parameter int FILTER_WIDTH         = 8,
  parameter int ADDR_WIDTH           = 10,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int LEN_WIDTH            = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           ifmap_base,
  input  logic [LEN_WIDTH-1:0]            row_len,
  input  logic [LEN_WIDTH-1:0]            num_rows,
  input  logic [ADDR_WIDTH-1:0]           filter_base,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  output logic                            ifmap_mem_ren,
  output logic [ADDR_WIDTH-1:0]           ifmap_mem_addr,
  input  logic [IFMAP_WIDTH-3:0]          ifmap_mem_rdata,
  output logic                            filter_mem_ren,
  output logic [ADDR_WIDTH-1:0]           filter_mem_addr,
  input  logic [FILTER_WIDTH-1:0]         filter_mem_rdata,
  input  logic                            ifmap_ready,
  input  logic                            filter_ready,
  output logic [IFMAP_WIDTH-1:0]          IFMap_in,
  output logic                            wen_IFMap_buffer,
  output logic [FILTER_WIDTH-1:0]         Filter_in,
  output logic                            wen_Filter_buffer,
  output logic                            busy,
  output logic                            done
);

  top_state_t state, state_nxt;
  logic       accept, ifmap_fin, filter_fin;

  assign accept = start && (state == TOP_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TOP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TOP_IDLE:   if (start) state_nxt = TOP_RUN;
      TOP_RUN:    if (ifmap_fin && filter_fin) state_nxt = TOP_FINISH;
      TOP_FINISH: state_nxt = TOP_IDLE;
      default:    state_nxt = TOP_IDLE;
    endcase
  end

  assign busy = (state != TOP_IDLE);
  assign done = (state == TOP_FINISH);

  feed_channel #(
    .DATA_W  (IFMAP_WIDTH),
    .RDATA_W (IFMAP_WIDTH - 2),
    .ADDR_W  (ADDR_WIDTH),
    .LEN_W   (LEN_WIDTH),
    .ROW_TAG (1'b1)
  ) u_ifmap (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .clear     (done),
    .base      (ifmap_base),
    .row_len   (row_len),
    .num_rows  (num_rows),
    .ready     (ifmap_ready),
    .mem_ren   (ifmap_mem_ren),
    .mem_addr  (ifmap_mem_addr),
    .mem_rdata (ifmap_mem_rdata),
    .wr_data   (IFMap_in),
    .wr_en     (wen_IFMap_buffer),
    .fin       (ifmap_fin)
  );

  // The filter stream is a single "row" of filter_size words.
  feed_channel #(
    .DATA_W  (FILTER_WIDTH),
    .RDATA_W (FILTER_WIDTH),
    .ADDR_W  (ADDR_WIDTH),
    .LEN_W   (FILTER_SIZE_REG_SIZE),
    .ROW_TAG (1'b0)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .clear     (done),
    .base      (filter_base),
    .row_len   (filter_size),
    .num_rows  (FILTER_SIZE_REG_SIZE'(1)),
    .ready     (filter_ready),
    .mem_ren   (filter_mem_ren),
    .mem_addr  (filter_mem_addr),
    .mem_rdata (filter_mem_rdata),
    .wr_data   (Filter_in),
    .wr_en     (wen_Filter_buffer),
    .fin       (filter_fin)
  );

endmodule

// File: tb/tb_pe_feeder.sv
// Directed self-checking bench for pe_feeder with behavioural sync-read memories.
module tb_pe_feeder;
  import pe_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  ifmap_base, filter_base;
  logic [7:0]  row_len, num_rows, filter_size;
  logic        ifmap_mem_ren, filter_mem_ren;
  logic [9:0]  ifmap_mem_addr, filter_mem_addr;
  logic [15:0] ifmap_mem_rdata;
  logic [7:0]  filter_mem_rdata;
  logic        ifmap_ready, filter_ready;
  logic [17:0] IFMap_in;
  logic        wen_IFMap_buffer;
  logic [7:0]  Filter_in;
  logic        wen_Filter_buffer;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc, dn, dnc, bad_ren;
  logic [9:0]  ia[$], fa[$];
  logic [17:0] iw[$];
  logic [7:0]  fw[$];
  int          iac[$], iwc[$];

  pe_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .ifmap_base(ifmap_base), .row_len(row_len), .num_rows(num_rows),
    .filter_base(filter_base), .filter_size(filter_size),
    .ifmap_mem_ren(ifmap_mem_ren), .ifmap_mem_addr(ifmap_mem_addr), .ifmap_mem_rdata(ifmap_mem_rdata),
    .filter_mem_ren(filter_mem_ren), .filter_mem_addr(filter_mem_addr), .filter_mem_rdata(filter_mem_rdata),
    .ifmap_ready(ifmap_ready), .filter_ready(filter_ready),
    .IFMap_in(IFMap_in), .wen_IFMap_buffer(wen_IFMap_buffer),
    .Filter_in(Filter_in), .wen_Filter_buffer(wen_Filter_buffer),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] imem(input logic [9:0] a);
    return {6'h15, a};
  endfunction

  function automatic logic [7:0] fmem(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [17:0] exp_if(input logic [9:0] b, input int rl, input int i);
    logic [9:0] a;
    a = b + 10'(i);
    return {((i % rl) == 0), ((i % rl) == rl - 1), imem(a)};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifmap_mem_ren)  ifmap_mem_rdata  <= imem(ifmap_mem_addr);
    if (filter_mem_ren) filter_mem_rdata <= fmem(filter_mem_addr);
  end

  always @(negedge clk) begin
    if (ifmap_mem_ren) begin
      ia.push_back(ifmap_mem_addr);
      iac.push_back(cyc);
      if (!ifmap_ready) bad_ren++;
    end
    if (filter_mem_ren) fa.push_back(filter_mem_addr);
    if (wen_IFMap_buffer) begin
      iw.push_back(IFMap_in);
      iwc.push_back(cyc);
    end
    if (wen_Filter_buffer) fw.push_back(Filter_in);
    if (done) begin
      dn++;
      dnc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ia.delete(); fa.delete(); iw.delete(); fw.delete(); iac.delete(); iwc.delete();
    dn = 0; dnc = -1; bad_ren = 0;
  endtask

  task automatic launch(input logic [9:0] ib, input logic [7:0] rl, input logic [7:0] nr,
                        input logic [9:0] fb, input logic [7:0] fs);
    ifmap_base = ib; row_len = rl; num_rows = nr; filter_base = fb; filter_size = fs;
    start = 1'b1;
    st_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (dn == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (dn != 0);
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, ifmap_mem_ren, filter_mem_ren, wen_IFMap_buffer, wen_Filter_buffer} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, done, ifmap_mem_ren, filter_mem_ren, wen_IFMap_buffer, wen_Filter_buffer});
    end
    checks++;
    if ({ifmap_mem_addr, filter_mem_addr, IFMap_in, Filter_in} !== 46'b0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {ifmap_mem_addr, filter_mem_addr, IFMap_in, Filter_in});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    launch(10'd100, 8'd4, 8'd2, 10'd200, 8'd3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_timeout: got 0 expected 1"); end
    checks++;
    if (iw.size() != 8 || fw.size() != 3) begin
      errors++; $display("FAIL basic_counts: got %0d/%0d expected 8/3", iw.size(), fw.size());
    end
    for (int i = 0; i < iw.size() && i < 8; i++) begin
      checks++;
      if (iw[i] !== exp_if(10'd100, 4, i) || ia[i] !== 10'(100 + i)) begin
        errors++; $display("FAIL basic_ifmap[%0d]: got %h@%0d expected %h@%0d", i, iw[i], ia[i], exp_if(10'd100, 4, i), 100 + i);
      end
    end
    for (int i = 0; i < fw.size() && i < 3; i++) begin
      checks++;
      if (fw[i] !== fmem(10'(200 + i)) || fa[i] !== 10'(200 + i)) begin
        errors++; $display("FAIL basic_filter[%0d]: got %h@%0d expected %h@%0d", i, fw[i], fa[i], fmem(10'(200 + i)), 200 + i);
      end
    end
    checks++;
    if (iac.size() != 8 || iac[0] != st_cyc + 1 || iwc[7] != iac[7] + 1 || dnc != st_cyc + 10) begin
      errors++; $display("FAIL basic_timing: got first_ren=%0d done=%0d expected %0d/%0d",
                         (iac.size() > 0) ? iac[0] : -1, dnc, st_cyc + 1, st_cyc + 10);
    end
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || dn != 1) begin
      errors++; $display("FAIL basic_idle_after: got busy=%b dones=%0d expected 0/1", busy, dn);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = 0, wb, ab;
    clear_logs();
    launch(10'd700, 8'd4, 8'd2, 10'd800, 8'd2);
    while (ia.size() < 2 && n < 20) begin step(); n++; end
    ifmap_ready = 1'b0;
    wb = iw.size();
    ab = ia.size();
    repeat (5) step();
    checks++;
    if (ia.size() != ab || iw.size() != wb + 1) begin
      errors++; $display("FAIL bp_stall: got issues=%0d writes=%0d expected %0d/%0d", ia.size(), iw.size(), ab, wb + 1);
    end
    ifmap_ready = 1'b1;
    wait_done(ok);
    checks++;
    if (!ok || iw.size() != 8 || bad_ren != 0) begin
      errors++; $display("FAIL bp_total: got done=%b writes=%0d bad_ren=%0d expected 1/8/0", ok, iw.size(), bad_ren);
    end
    for (int i = 0; i < iw.size() && i < 8; i++) begin
      checks++;
      if (iw[i] !== exp_if(10'd700, 4, i)) begin
        errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, iw[i], exp_if(10'd700, 4, i));
      end
    end
  endtask

  task automatic test_zero();
    bit ok;
    clear_logs();
    launch(10'd50, 8'd1, 8'd2, 10'd70, 8'd0);
    wait_done(ok);
    checks++;
    if (!ok || fw.size() != 0 || fa.size() != 0 || iw.size() != 2) begin
      errors++; $display("FAIL zero_filter: got done=%b fw=%0d iw=%0d expected 1/0/2", ok, fw.size(), iw.size());
    end
    for (int i = 0; i < iw.size() && i < 2; i++) begin
      checks++;
      if (iw[i][SOR_BIT] !== 1'b1 || iw[i][EOR_BIT] !== 1'b1 || iw[i] !== exp_if(10'd50, 1, i)) begin
        errors++; $display("FAIL zero_rowlen1[%0d]: got %h expected %h", i, iw[i], exp_if(10'd50, 1, i));
      end
    end
    clear_logs();
    launch(10'd0, 8'd0, 8'd0, 10'd0, 8'd0);
    wait_done(ok);
    checks++;
    if (!ok || dnc != st_cyc + 2 || ia.size() != 0 || fa.size() != 0) begin
      errors++; $display("FAIL zero_all: got done_cyc=%0d issues=%0d expected %0d/0", dnc, ia.size() + fa.size(), st_cyc + 2);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0] exp_ia[4];
    exp_ia = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    clear_logs();
    launch(10'd1022, 8'd4, 8'd1, 10'd1023, 8'd2);
    wait_done(ok);
    checks++;
    if (!ok || ia.size() != 4 || fa.size() != 2) begin
      errors++; $display("FAIL wrap_counts: got %0d/%0d expected 4/2", ia.size(), fa.size());
    end
    for (int i = 0; i < ia.size() && i < 4; i++) begin
      checks++;
      if (ia[i] !== exp_ia[i] || iw[i] !== exp_if(10'd1022, 4, i)) begin
        errors++; $display("FAIL wrap_ifmap[%0d]: got %0d/%h expected %0d/%h", i, ia[i], iw[i], exp_ia[i], exp_if(10'd1022, 4, i));
      end
    end
    checks++;
    if (fa.size() == 2 && (fa[0] !== 10'd1023 || fa[1] !== 10'd0 || fw[1] !== 8'h5A)) begin
      errors++; $display("FAIL wrap_filter: got %0d,%0d expected 1023,0", fa[0], fa[1]);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    clear_logs();
    launch(10'd500, 8'd3, 8'd2, 10'd600, 8'd2);
    step();
    launch(10'd10, 8'd1, 8'd1, 10'd20, 8'd5);
    wait_done(ok);
    checks++;
    if (!ok || iw.size() != 6 || fw.size() != 2) begin
      errors++; $display("FAIL busy_counts: got %0d/%0d expected 6/2", iw.size(), fw.size());
    end
    for (int i = 0; i < iw.size() && i < 6; i++) begin
      checks++;
      if (iw[i] !== exp_if(10'd500, 3, i)) begin
        errors++; $display("FAIL busy_word[%0d]: got %h expected %h", i, iw[i], exp_if(10'd500, 3, i));
      end
    end
    repeat (8) step();
    checks++;
    if (dn != 1 || busy !== 1'b0 || fa.size() != 2 || fa[1] !== 10'd601) begin
      errors++; $display("FAIL busy_ignored: got dones=%0d busy=%b expected 1/0", dn, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    launch(10'd300, 8'd4, 8'd2, 10'd400, 8'd3);
    checks++;
    if (ifmap_mem_ren !== 1'b1 || filter_mem_ren !== 1'b1) begin
      errors++; $display("FAIL rstmid_ren: got %b%b expected 11", ifmap_mem_ren, filter_mem_ren);
    end
    rst = 1'b1;
    repeat (3) step();
    test_reset();
    checks++;
    if (iw.size() != 0 || fw.size() != 0) begin
      errors++; $display("FAIL rstmid_no_wen: got %0d/%0d expected 0/0", iw.size(), fw.size());
    end
    rst = 1'b0;
    step();
    clear_logs();
    launch(10'd40, 8'd2, 8'd1, 10'd60, 8'd1);
    wait_done(ok);
    checks++;
    if (!ok || iw.size() != 2 || fw.size() != 1 || iw[1] !== exp_if(10'd40, 2, 1) || fw[0] !== fmem(10'd60)) begin
      errors++; $display("FAIL rstmid_clean_job: got done=%b iw=%0d fw=%0d expected 1/2/1", ok, iw.size(), fw.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ifmap_ready = 1'b1; filter_ready = 1'b1;
    ifmap_base = '0; filter_base = '0; row_len = '0; num_rows = '0; filter_size = '0;
    clear_logs();
    repeat (3) step();
    test_reset();
    rst = 1'b0;
    step();
    test_basic();
    test_backpressure();
    test_zero();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Streams one convolution job's filter weights and IFMap rows from two synchronous-read memories into a PE's IFMap and Filter input FIFOs. It is the producer for the PE's `IFMap_in`/`wen_IFMap_buffer` and `Filter_in`/`wen_Filter_buffer` ports. It tags each IFMap word with the row-boundary flags the PE scratch-pad controller consumes. It sits between the job-level controller (start/done) and the PE.

## Interface
Parameters:
- `IFMAP_WIDTH`, 18, IFMap word width: 16 data bits plus 2 flag bits.
- `FILTER_WIDTH`, 8, filter word width.
- `ADDR_WIDTH`, 10, memory address width for both memories.
- `FILTER_SIZE_REG_SIZE`, 8, width of `filter_size`.
- `LEN_WIDTH`, 8, width of `row_len` and `num_rows`.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle job start; ignored while `busy`.
- `ifmap_base`  in  ADDR_WIDTH  first IFMap word address.
- `row_len`  in  LEN_WIDTH  words per IFMap row.
- `num_rows`  in  LEN_WIDTH  rows per job.
- `filter_base`  in  ADDR_WIDTH  first filter word address.
- `filter_size`  in  FILTER_SIZE_REG_SIZE  filter words per job.
- `ifmap_mem_ren`, `ifmap_mem_addr`  out  1 / ADDR_WIDTH  IFMap memory read request.
- `ifmap_mem_rdata`  in  IFMAP_WIDTH-2  IFMap read data, valid the cycle after `ifmap_mem_ren`.
- `filter_mem_ren`, `filter_mem_addr`  out  1 / ADDR_WIDTH  filter memory read request.
- `filter_mem_rdata`  in  FILTER_WIDTH  filter read data, valid the cycle after `filter_mem_ren`.
- `ifmap_ready`  in  1  the PE IFMap FIFO has room for at least 2 words.
- `filter_ready`  in  1  the PE Filter FIFO has room for at least 2 words.
- `IFMap_in`, `wen_IFMap_buffer`  out  IFMAP_WIDTH / 1  IFMap word and write strobe to the PE.
- `Filter_in`, `wen_Filter_buffer`  out  FILTER_WIDTH / 1  filter word and write strobe to the PE.
- `busy`  out  1  a job is in progress.
- `done`  out  1  one-cycle pulse when the job completes.

## Operation
- IFMap word format:
  - bit IFMAP_WIDTH-1 = start-of-row flag; set on word 0 of each row.
  - bit IFMAP_WIDTH-2 = end-of-row flag; set on word `row_len`-1 of each row.
  - When `row_len`=1, both flags are set on the same word.
  - Bits [IFMAP_WIDTH-3:0] = `ifmap_mem_rdata`.
- On an accepted `start`, latch all configuration and assert `busy`. The filter and IFMap channels then run concurrently and independently.
- Top FSM:
  - IDLE → RUN on `start`.
  - RUN → FINISH when both channels have written their last word.
  - FINISH → IDLE after one cycle; `done`=1 in FINISH.
- Channel FSM (one per channel):
  - IDLE → ISSUE on start.
  - ISSUE: assert `*_mem_ren` for the current address when `*_ready`=1. Advance the address and the word count on each issue.
  - ISSUE → DRAIN after issuing the last word.
  - DRAIN → DONE once the last word has been written.
- IFMap addresses are linear: `ifmap_base` + row·`row_len` + col. Filter addresses are `filter_base` + k.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Zero length: if `filter_size`=0, or `row_len`=0, or `num_rows`=0, that channel goes directly to DONE and issues nothing. If both channels are zero-length, `done` fires 2 cycles after `start`.
- Backpressure: the `*_ready` margin of 2 covers the one in-flight read. The write one cycle after an issue is unconditional; no skid storage.
- `start` while `busy`: ignored, configuration unchanged.
- Reset mid-job: all state returns to IDLE immediately. In-flight reads are discarded and no write strobe fires after reset.

## Timing
- Reset values:
  - All outputs 0: `busy`, `done`, both `*_mem_ren`, both `wen_*`, both addresses, `IFMap_in`, `Filter_in`.
- Latency:
  - `start` at cycle N; first `*_mem_ren` no earlier than N+1.
  - The matching `wen_*` is exactly 1 cycle after its `*_mem_ren`.
- Throughput: 1 word per cycle per channel while `*_ready`=1.
- `busy` rises at N+1 and falls with the `done` cycle.
- `done` is asserted 1 cycle after the later channel's final `wen_*`.
- `IFMap_in` and `Filter_in` are registered and change only together with their strobe.

## Structure
- Shared package `pe_feeder_pkg`:
  - channel state enum (IDLE, ISSUE, DRAIN, DONE);
  - top state enum;
  - flag bit-position constants `SOR_BIT` and `EOR_BIT`, used with the PE datapath.
- Sub-module `feed_channel`:
  - address/count generator, issue logic and 1-cycle write-strobe pipe;
  - parameterised by data width and by an `ROW_TAG` enable;
  - instantiated twice.

## Test plan
- Basic job: `filter_size`=3, `row_len`=4, `num_rows`=2, ready held at 1 → 3 filter writes and 8 IFMap writes. Flags set on IFMap words 0 and 4 (SOR) and words 3 and 7 (EOR). `done` fires one cycle after the last write; addresses are sequential from the bases.
- Backpressure: drop `ifmap_ready` for 5 cycles mid-row → no issue while low; exactly one in-flight write completes; no data lost or duplicated; order preserved.
- Zero lengths: `filter_size`=0, `num_rows`=2, `row_len`=1 → no filter traffic; each IFMap word has SOR=EOR=1. Separately, all lengths 0 → `done` at `start`+2.
- Wrap: `ifmap_base`=1022, ADDR_WIDTH=10, `row_len`=4 → addresses 1022, 1023, 0, 1.
- `start` pulsed while `busy` with different config → ignored; the original job completes unchanged.
- Assert `rst` the cycle after a `*_mem_ren` → no `wen_*` follows; all outputs are 0; a new `start` runs a clean job.
